instr_fetch_unit: RTL and testbench

//  Front-end fetch stage directly upstream of decode/immediate generation. Owns the PC,

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word reads to instruction memory,
// queues responses with their PCs and hands {instr, instr_pc} to decode.
// A redirect flushes the queue and discards responses still in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]           fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         fill_ptr_q, fill_ptr_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [CW-1:0]         unf_q, unf_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [31:0]           ent_pc_q   [FIFO_DEPTH];
    logic [31:0]           ent_pc_d   [FIFO_DEPTH];
    logic [31:0]           ent_data_q [FIFO_DEPTH];
    logic [31:0]           ent_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_filled_q, ent_filled_d;

    logic [SW-1:0] credit_sum;
    logic          req_fire;
    logic          deq;
    logic          rsp_fill;
    logic          rsp_drop;

    // Handshake qualifiers; requests in flight (kept or to be dropped) consume credits
    always_comb begin
        credit_sum     = SW'(occ_q) + SW'(drop_cnt_q);
        imem_req_valid = (credit_sum < SW'(FIFO_DEPTH)) & ~redirect_valid;
        imem_req_addr  = fetch_pc_q;
        instr_valid    = ent_filled_q[rd_ptr_q] & ~redirect_valid;
        instr          = ent_data_q[rd_ptr_q];
        instr_pc       = ent_pc_q[rd_ptr_q];
        req_fire       = imem_req_valid & imem_req_ready;
        deq            = instr_valid & instr_ready;
        rsp_fill       = imem_rsp_valid & (drop_cnt_q == '0);
        rsp_drop       = imem_rsp_valid & (drop_cnt_q != '0);
    end

    // Next-state: queue allocate/fill/dequeue, or flush on redirect
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fill_ptr_d   = fill_ptr_q;
        occ_d        = occ_q;
        unf_d        = unf_q;
        drop_cnt_d   = drop_cnt_q;
        ent_pc_d     = ent_pc_q;
        ent_data_d   = ent_data_q;
        ent_filled_d = ent_filled_q;

        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc & ~32'h3;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fill_ptr_d   = '0;
            occ_d        = '0;
            unf_d        = '0;
            ent_filled_d = '0;
            // Outstanding unfilled requests become drops, minus one returning now
            drop_cnt_d   = drop_cnt_q + unf_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d             = fetch_pc_q + 32'd4;
                ent_pc_d[wr_ptr_q]     = fetch_pc_q;
                ent_filled_d[wr_ptr_q] = 1'b0;
                wr_ptr_d               = wr_ptr_q + AW'(1);
            end
            if (rsp_fill) begin
                ent_data_d[fill_ptr_q]   = imem_rsp_data;
                ent_filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d               = fill_ptr_q + AW'(1);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (deq) begin
                ent_filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d               = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + CW'(req_fire) - CW'(deq);
            unf_d = unf_q + CW'(req_fire) - CW'(rsp_fill);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fill_ptr_q   <= '0;
            occ_q        <= '0;
            unf_q        <= '0;
            drop_cnt_q   <= '0;
            ent_pc_q     <= '{default: '0};
            ent_data_q   <= '{default: '0};
            ent_filled_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_ptr_q   <= fill_ptr_d;
            occ_q        <= occ_d;
            unf_q        <= unf_d;
            drop_cnt_q   <= drop_cnt_d;
            ent_pc_q     <= ent_pc_d;
            ent_data_q   <= ent_data_d;
            ent_filled_q <= ent_filled_d;
        end
    end

    // A response must always have an unfilled entry or a pending drop to consume it
    rsp_has_target: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (drop_cnt_q == '0) && (unf_q == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a cycle table with hand-computed outputs, then
// sequences against a fixed-latency memory model with in-order expectations.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        i_rdy;
        logic        rd_v;
        logic [31:0] rd_pc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic rq, input logic rv, input logic [31:0] rd,
                                input logic ir, input logic redv, input logic [31:0] rpc,
                                input logic erv, input logic [31:0] eaddr, input logic eiv,
                                input logic [31:0] eipc, input logic [31:0] edata);
        vec_t v;
        v.rq_rdy = rq;  v.rsp_v = rv;   v.rsp_d = rd;   v.i_rdy = ir;
        v.rd_v = redv;  v.rd_pc = rpc;  v.e_rv = erv;   v.e_addr = eaddr;
        v.e_iv = eiv;   v.e_ipc = eipc; v.e_data = edata;
        return v;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic        mem_rdy, dec_rdy, redir;
    logic [31:0] redir_pc;
    int          lat;
    int          cyc;
    logic [31:0] exp_req_addr, exp_ipc;
    int          n_fire, n_deq, first_iv;
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_ipc, s_idata;

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        #1;
        check32("reset req_valid", 32'(imem_req_valid), 32'd1);
        check32("reset req_addr", imem_req_addr, RESET_PC);
        check32("reset instr_valid", 32'(instr_valid), 32'd0);
        check32("reset instr", instr, 32'd0);
        check32("reset instr_pc", instr_pc, 32'd0);
        pend.delete();
        redir        = 1'b0;
        redir_pc     = '0;
        exp_req_addr = RESET_PC;
        exp_ipc      = RESET_PC;
        n_fire       = 0;
        n_deq        = 0;
        first_iv     = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc = 0;
    endtask

    task automatic cycle();
        pend_t p;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        imem_req_ready = mem_rdy;
        instr_ready    = dec_rdy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        #1;
        s_rv    = imem_req_valid;
        s_addr  = imem_req_addr;
        s_iv    = instr_valid;
        s_ipc   = instr_pc;
        s_idata = instr;
        if (redir) begin
            check32("redirect blocks request", 32'(s_rv), 32'd0);
            check32("redirect blocks instr", 32'(s_iv), 32'd0);
        end
        if (s_rv && mem_rdy) begin
            check32("req_addr order", s_addr, exp_req_addr);
            p.addr = s_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            exp_req_addr = exp_req_addr + 32'd4;
            n_fire++;
        end
        if (s_iv && first_iv < 0) first_iv = cyc;
        if (s_iv && dec_rdy) begin
            check32("instr_pc order", s_ipc, exp_ipc);
            check32("instr data", s_idata, mem_word(s_ipc));
            exp_ipc = exp_ipc + 32'd4;
            n_deq++;
        end
        if (redir) begin
            exp_req_addr = redir_pc & ~32'h3;
            exp_ipc      = redir_pc & ~32'h3;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        vec_t tbl[26];
        int   stall;
        logic stalled;
        logic saw_iv;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        mem_rdy = 1'b0; dec_rdy = 1'b0; redir = 1'b0; redir_pc = '0; lat = 1; cyc = 0;

        //          rq rv rsp_d          ir rd rd_pc          erv e_addr         eiv e_ipc          e_data
        tbl[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
        tbl[1]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
        tbl[2]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         32'h0);
        tbl[3]  = mk(1, 1, 32'hA000_0000, 0, 0, 32'h0,         0, 32'h8,         0, 32'h0,         32'h0);
        tbl[4]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8,         1, 32'h0,         32'hA000_0000);
        tbl[5]  = mk(1, 1, 32'hA000_0004, 1, 0, 32'h0,         0, 32'h8,         1, 32'h0,         32'hA000_0000);
        tbl[6]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'hA000_0004);
        tbl[7]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'hA000_0004);
        tbl[8]  = mk(1, 0, 32'h0,         1, 1, 32'h103,       0, 32'hC,         0, 32'h0,         32'h0);
        tbl[9]  = mk(1, 1, 32'hA000_0008, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0);
        tbl[10] = mk(1, 1, 32'hB000_0000, 0, 0, 32'h0,         1, 32'h104,       0, 32'h0,         32'h0);
        tbl[11] = mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h108,       1, 32'h100,       32'hB000_0000);
        tbl[12] = mk(1, 1, 32'hB000_0004, 1, 1, 32'h200,       0, 32'h108,       0, 32'h0,         32'h0);
        tbl[13] = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0);
        tbl[14] = mk(0, 1, 32'hC000_0000, 0, 0, 32'h0,         1, 32'h204,       0, 32'h0,         32'h0);
        tbl[15] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h204,       1, 32'h200,       32'hC000_0000);
        tbl[16] = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h204,       0, 32'h0,         32'h0);
        tbl[17] = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h208,       0, 32'h0,         32'h0);
        tbl[18] = mk(1, 0, 32'h0,         0, 1, 32'h300,       0, 32'h20C,       0, 32'h0,         32'h0);
        tbl[19] = mk(1, 1, 32'hE000_0000, 0, 1, 32'h400,       0, 32'h300,       0, 32'h0,         32'h0);
        tbl[20] = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h400,       0, 32'h0,         32'h0);
        tbl[21] = mk(1, 1, 32'hE000_0004, 0, 0, 32'h0,         0, 32'h404,       0, 32'h0,         32'h0);
        tbl[22] = mk(1, 1, 32'hD000_0000, 0, 0, 32'h0,         1, 32'h404,       0, 32'h0,         32'h0);
        tbl[23] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h408,       1, 32'h400,       32'hD000_0000);
        tbl[24] = mk(0, 1, 32'hD000_0004, 1, 0, 32'h0,         1, 32'h408,       0, 32'h0,         32'h0);
        tbl[25] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h408,       1, 32'h404,       32'hD000_0004);

        // Table: credits, stalls, back-pressure, redirects with drops
        do_reset();
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            imem_req_ready = tbl[i].rq_rdy;
            imem_rsp_valid = tbl[i].rsp_v;
            imem_rsp_data  = tbl[i].rsp_d;
            instr_ready    = tbl[i].i_rdy;
            redirect_valid = tbl[i].rd_v;
            redirect_pc    = tbl[i].rd_pc;
            #1;
            check32($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            check32($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            check32($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                check32($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].e_ipc);
                check32($sformatf("row%0d instr", i), instr, tbl[i].e_data);
            end
            @(posedge clk);
        end

        // Streaming with 1-cycle memory
        do_reset();
        lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b1;
        repeat (20) cycle();
        check32("stream first instr_valid cycle", 32'(first_iv), 32'd2);
        check32("stream instr count", 32'(n_deq), 32'd12);

        // Decode stalled: two requests, then credits exhausted, head held
        do_reset();
        lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i >= 2) begin
                check32("stall instr_valid", 32'(s_iv), 32'd1);
                check32("stall instr_pc held", s_ipc, 32'h0);
                check32("stall instr held", s_idata, mem_word(32'h0));
                check32("stall req_valid off", 32'(s_rv), 32'd0);
            end
        end
        check32("stall request count", 32'(n_fire), 32'd2);
        dec_rdy = 1'b1;
        repeat (10) cycle();
        check32("stall release delivered", 32'(n_deq >= 3), 32'd1);

        // Memory not ready at PC 0x8: address holds
        do_reset();
        lat = 1; dec_rdy = 1'b1; stall = 0;
        for (int i = 0; i < 16; i++) begin
            stalled = (exp_req_addr == 32'h8) && (stall < 3);
            mem_rdy = ~stalled;
            cycle();
            if (stalled) begin
                stall++;
                check32("req_ready low addr held", s_addr, 32'h8);
            end
        end
        check32("req_ready low stall cycles", 32'(stall), 32'd3);
        check32("req_ready low progress", 32'(n_deq >= 6), 32'd1);
        mem_rdy = 1'b1;

        // Redirect with two requests in flight to a 3-cycle memory
        do_reset();
        lat = 3; mem_rdy = 1'b1; dec_rdy = 1'b1;
        repeat (2) cycle();
        redir = 1'b1; redir_pc = 32'h100;
        cycle();
        redir = 1'b0;
        n_deq = 0;
        repeat (12) cycle();
        check32("redirect 0x100 delivered", 32'(n_deq >= 2), 32'd1);
        redir = 1'b1; redir_pc = 32'h103;
        cycle();
        redir = 1'b0;
        cycle();
        check32("redirect 0x103 aligned addr", s_addr, 32'h100);
        repeat (12) cycle();

        // Wrap past the top of the address space, then reset mid-stream
        do_reset();
        lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b1;
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        cycle();
        redir = 1'b0;
        n_fire = 0; n_deq = 0; saw_iv = 1'b0;
        repeat (8) begin
            cycle();
            saw_iv = saw_iv | s_iv;
        end
        check32("wrap fetches", 32'(n_fire >= 4), 32'd1);
        check32("wrap delivered past zero", 32'(n_deq >= 4), 32'd1);
        check32("wrap stream active", 32'(saw_iv), 32'd1);
        do_reset();
        lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b1;
        repeat (8) cycle();
        check32("restart after reset", 32'(n_deq >= 4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
